// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: drives the shared master_timer countdown and the
// per-approach enables, inserts all-red clearance and converts it to a walk on request.
module intersection_controller #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int GREEN_TIME   = 60,
   parameter int ALL_RED_TIME = 2,
   parameter int PED_TIME     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_request,
   output logic       enable_ns,
   output logic       enable_ew,
   output logic [6:0] master_timer,
   output logic       ped_walk,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      NS_GO    = 2'd0,
      NS_CLEAR = 2'd1,
      EW_GO    = 2'd2,
      EW_CLEAR = 2'd3
   } phase_t;

   localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [6:0]  GREEN_INIT  = 7'(GREEN_TIME);
   localparam logic [7:0]  ALL_RED_M1  = 8'(ALL_RED_TIME - 1);
   localparam logic [7:0]  PED_M1      = 8'(PED_TIME - 1);
   localparam logic [6:0]  YELLOW_TIME = 7'd15;

   phase_t          state_r;
   logic [PW-1:0]   presc_r;
   logic [7:0]      clr_cnt_r;
   logic            ped_pending_r;
   logic            tick_s;
   logic            go_s;
   logic            clear_entry_s;

   assign phase = state_r;

   // Tick strobe and detection of the GO -> CLEAR edge.
   always_comb begin
      tick_s        = (presc_r == PRESC_MAX);
      go_s          = (state_r == NS_GO) || (state_r == EW_GO);
      clear_entry_s = tick_s && go_s && (master_timer == 7'd0);
   end

   // Prescaler counting 0..TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_r <= '0;
      end else if (tick_s) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
      end
   end

   // Sticky pedestrian flag; cleared only when a clearance begins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ped_pending_r <= 1'b0;
      end else if (clear_entry_s) begin
         ped_pending_r <= 1'b0;
      end else if (ped_request) begin
         ped_pending_r <= 1'b1;
      end else begin
         ped_pending_r <= ped_pending_r;
      end
   end

   // Phase sequencer with registered enables, timer and walk indication.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= EW_CLEAR;
         enable_ns    <= 1'b0;
         enable_ew    <= 1'b0;
         master_timer <= 7'd0;
         ped_walk     <= 1'b0;
         clr_cnt_r    <= ALL_RED_M1;
      end else if (tick_s) begin
         case (state_r)
            NS_GO, EW_GO: begin
               if (master_timer == 7'd0) begin
                  state_r   <= (state_r == NS_GO) ? NS_CLEAR : EW_CLEAR;
                  enable_ns <= 1'b0;
                  enable_ew <= 1'b0;
                  // A request seen on the entry edge itself still earns the walk.
                  if (ped_pending_r || ped_request) begin
                     ped_walk  <= 1'b1;
                     clr_cnt_r <= PED_M1;
                  end else begin
                     clr_cnt_r <= ALL_RED_M1;
                  end
               end else if (ped_pending_r && (master_timer > YELLOW_TIME)) begin
                  master_timer <= YELLOW_TIME;
               end else begin
                  master_timer <= master_timer - 7'd1;
               end
            end
            NS_CLEAR, EW_CLEAR: begin
               if (clr_cnt_r == 8'd0) begin
                  state_r      <= (state_r == NS_CLEAR) ? EW_GO : NS_GO;
                  master_timer <= GREEN_INIT;
                  enable_ns    <= (state_r == EW_CLEAR);
                  enable_ew    <= (state_r == NS_CLEAR);
                  ped_walk     <= 1'b0;
               end else begin
                  clr_cnt_r <= clr_cnt_r - 8'd1;
               end
            end
            default: begin
               state_r <= EW_CLEAR;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench: two DUTs (tick every clock, tick every 4th clock) compared each
// cycle against a phase/ticks-remaining model, plus directed literal checks.
module tb_intersection_controller;

   localparam int G   = 20;
   localparam int AR  = 2;
   localparam int PED = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, req1, ns1, ew1, walk1;
   logic [6:0] mt1;
   logic [1:0] ph1;
   logic       rst2, req2, ns2, ew2, walk2;
   logic [6:0] mt2;
   logic [1:0] ph2;

   intersection_controller #(.TICK_DIV(1), .GREEN_TIME(G), .ALL_RED_TIME(AR), .PED_TIME(PED)) u1 (
      .clk(clk), .rst_n(rst1), .ped_request(req1), .enable_ns(ns1), .enable_ew(ew1),
      .master_timer(mt1), .ped_walk(walk1), .phase(ph1));

   intersection_controller #(.TICK_DIV(4), .GREEN_TIME(G), .ALL_RED_TIME(AR), .PED_TIME(PED)) u2 (
      .clk(clk), .rst_n(rst2), .ped_request(req2), .enable_ns(ns2), .enable_ew(ew2),
      .master_timer(mt2), .ped_walk(walk2), .phase(ph2));

   // Model: phase index, visible timer, clearance ticks still to run, walk, pending, prescaler.
   typedef struct {
      int ph;
      int tmr;
      int clr_left;
      bit walk;
      bit pend;
      int presc;
   } mdl_t;

   function automatic mdl_t step(mdl_t m, bit rst, bit req, int div);
      mdl_t n = m;
      bit   tick;
      if (!rst) begin
         n.ph = 3; n.tmr = 0; n.clr_left = AR; n.walk = 0; n.pend = 0; n.presc = 0;
         return n;
      end
      tick    = (m.presc == div - 1);
      n.presc = tick ? 0 : m.presc + 1;
      if (req) n.pend = 1;
      if (tick) begin
         if (m.ph % 2 == 0) begin
            if (m.tmr == 0) begin
               n.ph       = m.ph + 1;
               n.walk     = m.pend || req;
               n.clr_left = n.walk ? PED : AR;
               n.pend     = 0;
            end else if (m.pend && m.tmr > 15) begin
               n.tmr = 15;
            end else begin
               n.tmr = m.tmr - 1;
            end
         end else begin
            n.clr_left = m.clr_left - 1;
            if (n.clr_left == 0) begin
               n.ph   = (m.ph + 1) % 4;
               n.tmr  = G;
               n.walk = 0;
            end
         end
      end
      return n;
   endfunction

   mdl_t m1, m2;
   int   checks = 0;
   int   errors = 0;
   bit   armed  = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m1 <= step(m1, rst1, req1, 1);
      m2 <= step(m2, rst2, req2, 4);
   end

   always @(negedge clk) begin
      if (armed) begin
         check("m1_phase", int'(ph1), m1.ph);
         check("m1_ns", int'(ns1), int'(m1.ph == 0));
         check("m1_ew", int'(ew1), int'(m1.ph == 2));
         check("m1_timer", int'(mt1), m1.tmr);
         check("m1_walk", int'(walk1), int'(m1.walk));
         check("m1_excl", int'(ns1 & ew1), 0);
         check("m2_phase", int'(ph2), m2.ph);
         check("m2_ns", int'(ns2), int'(m2.ph == 0));
         check("m2_ew", int'(ew2), int'(m2.ph == 2));
         check("m2_timer", int'(mt2), m2.tmr);
         check("m2_walk", int'(walk2), int'(m2.walk));
      end
   end

   // Advance clocks until unit u shows the requested phase/timer (-1 = don't care);
   // ne selects "timer differs from mt". c counts clocks, w counts clocks with walk high.
   task automatic wait_for(input int u, input int ph, input int mt, input bit ne,
                           output int c, output int w);
      bit ok;
      c = 0; w = 0;
      forever begin
         int cp, cm, cw;
         cp = (u == 1) ? int'(ph1) : int'(ph2);
         cm = (u == 1) ? int'(mt1) : int'(mt2);
         cw = (u == 1) ? int'(walk1) : int'(walk2);
         ok = (ph < 0 || cp == ph) && (mt < 0 || (ne ? (cm != mt) : (cm == mt)));
         if (ok || c >= 300) break;
         if (cw != 0) w++;
         @(negedge clk);
         c++;
      end
      if (!ok) check("wait_timeout", 0, 1);
   endtask

   int c, w;

   initial begin
      rst1 = 1'b0; rst2 = 1'b0; req1 = 1'b0; req2 = 1'b0;
      @(posedge clk);
      armed = 1;
      repeat (3) @(negedge clk);
      check("rst_phase", int'(ph1), 3);
      check("rst_timer", int'(mt1), 0);
      check("rst_en", int'({ns1, ew1, walk1}), 0);

      rst1 = 1'b1;
      @(negedge clk);
      check("rel1_phase", int'(ph1), 3);
      @(negedge clk);
      check("rel2_phase", int'(ph1), 0);
      check("rel2_ns", int'(ns1), 1);
      check("rel2_timer", int'(mt1), 20);

      // Free-running cycle: 21 + 2 + 21 + 2 = 46 clocks.
      wait_for(1, 1, -1, 0, c, w); check("ns_go_len", c, 21);
      wait_for(1, 2, -1, 0, c, w); check("ns_clr_len", c, 2); check("ns_clr_walk", w, 0);
      wait_for(1, 3, -1, 0, c, w); check("ew_go_len", c, 21);
      wait_for(1, 0, -1, 0, c, w); check("ew_clr_len", c, 2);

      // Early request at timer 18: the edge that samples it still decrements, then 15.
      wait_for(1, 0, 18, 0, c, w);
      req1 = 1'b1; @(negedge clk); req1 = 1'b0;
      check("early_t17", int'(mt1), 17);
      @(negedge clk); check("early_t15", int'(mt1), 15);
      @(negedge clk); check("early_t14", int'(mt1), 14);
      wait_for(1, 1, -1, 0, c, w); check("early_go_rest", c, 15);
      wait_for(1, 2, -1, 0, c, w); check("early_clr_len", c, 5); check("early_clr_walk", w, 5);
      check("ew_entry_walk", int'(walk1), 0);

      // Late request at timer 10: no truncation, walk follows.
      wait_for(1, 2, 10, 0, c, w);
      req1 = 1'b1; @(negedge clk); req1 = 1'b0;
      check("late_t9", int'(mt1), 9);
      wait_for(1, 3, -1, 0, c, w);
      check("late_walk", int'(walk1), 1);

      // Request during the walk clearance: current clear unchanged, next go truncated.
      req1 = 1'b1; @(negedge clk); req1 = 1'b0;
      wait_for(1, 0, -1, 0, c, w); check("clrreq_len", c, 4); check("clrreq_walk", w, 4);
      check("clrreq_t20", int'(mt1), 20);
      @(negedge clk); check("clrreq_t15", int'(mt1), 15);
      wait_for(1, 1, -1, 0, c, w);
      wait_for(1, 2, -1, 0, c, w); check("clrreq_next_walk", w, 5);

      // Request on the GO->CLEAR edge itself.
      wait_for(1, 2, 0, 0, c, w);
      req1 = 1'b1; @(negedge clk); req1 = 1'b0;
      check("t0_phase", int'(ph1), 3);
      check("t0_walk", int'(walk1), 1);

      // Mid-phase reset at timer 7 in EW_GO.
      wait_for(1, 2, 7, 0, c, w);
      rst1 = 1'b0; @(negedge clk); rst1 = 1'b1;
      check("mid_phase", int'(ph1), 3);
      check("mid_out", int'({ns1, ew1, walk1}), 0);
      check("mid_timer", int'(mt1), 0);
      repeat (2) @(negedge clk);
      check("mid_rel_timer", int'(mt1), 20);

      // Slow tick: everything moves on every 4th clock only.
      rst2 = 1'b1;
      wait_for(2, 0, -1, 0, c, w); check("slow_rel_len", c, 8);
      check("slow_t20", int'(mt2), 20);
      wait_for(2, -1, 20, 1, c, w); check("slow_tick_gap", c, 4);
      check("slow_t19", int'(mt2), 19);
      req2 = 1'b1; @(negedge clk); req2 = 1'b0;
      check("slow_hold", int'(mt2), 19);
      wait_for(2, -1, 19, 1, c, w); check("slow_req_gap", c, 3);
      check("slow_t15", int'(mt2), 15);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
